// File: rtl/flex_dtack_watchdog.sv
// flex_dtack_watchdog: forwards slave acknowledges and terminates unanswered bus cycles with an error pattern
`ifndef BB_ADDR_BUS_WIDTH
`define BB_ADDR_BUS_WIDTH 16
`endif
module flex_dtack_watchdog #(
  parameter int addr_bus_width = `BB_ADDR_BUS_WIDTH,
  parameter int data_bus_width = 16,
  parameter int timeout_cycles = 32,
  parameter logic [15:0] timeout_pattern = 16'hDEAD
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [addr_bus_width-1:0] addr,
  input  logic                      sec_addr_strobe,
  input  logic                      rd_active,
  input  logic                      wr_active,
  input  logic                      slave_dtack,
  input  logic [data_bus_width-1:0] slave_data,
  input  logic                      clear_err,
  output logic                      master_dtack,
  output logic [data_bus_width-1:0] master_data,
  output logic                      busy,
  output logic                      timeout_flag,
  output logic [7:0]                err_count,
  output logic [addr_bus_width-1:0] err_addr
);
  localparam int cw = $clog2(timeout_cycles + 1);
  localparam logic [cw-1:0] last_cnt = cw'(timeout_cycles - 1);
  localparam logic [data_bus_width-1:0] pattern = data_bus_width'(timeout_pattern);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state;
  logic [cw-1:0] cnt;
  logic [addr_bus_width-1:0] cyc_addr;
  logic cyc_rd;
  // cycle tracking: acknowledge beats abort, abort beats timeout; clear_err lands before a coincident timeout
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      cyc_addr     <= '0;
      cyc_rd       <= 1'b0;
      master_dtack <= 1'b0;
      master_data  <= '0;
      busy         <= 1'b0;
      timeout_flag <= 1'b0;
      err_count    <= '0;
      err_addr     <= '0;
    end else begin
      master_dtack <= 1'b0;
      if (clear_err) begin
        timeout_flag <= 1'b0;
        err_count    <= '0;
      end
      case (state)
        IDLE: if (sec_addr_strobe && (rd_active || wr_active)) begin
          state    <= WAIT;
          busy     <= 1'b1;
          cyc_addr <= addr;
          cyc_rd   <= rd_active;
          cnt      <= '0;
        end
        WAIT: if (slave_dtack) begin
          master_dtack <= 1'b1;
          master_data  <= cyc_rd ? slave_data : master_data;
          state        <= DONE;
        end else if (!sec_addr_strobe) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else if (cnt == last_cnt) begin
          master_dtack <= 1'b1;
          master_data  <= cyc_rd ? pattern : master_data;
          timeout_flag <= 1'b1;
          err_count    <= clear_err ? 8'd1 : err_count + {7'd0, err_count != 8'hFF};
          err_addr     <= cyc_addr;
          state        <= DONE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        DONE: if (!sec_addr_strobe && !rd_active && !wr_active) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_flex_dtack_watchdog.sv
// tb_flex_dtack_watchdog: scoreboard bench for the bus-cycle watchdog
module tb_flex_dtack_watchdog;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [15:0] addr = '0;
  logic sec_addr_strobe = 1'b0;
  logic rd_active = 1'b0;
  logic wr_active = 1'b0;
  logic slave_dtack = 1'b0;
  logic [15:0] slave_data = '0;
  logic clear_err = 1'b0;
  logic master_dtack;
  logic [15:0] master_data;
  logic busy;
  logic timeout_flag;
  logic [7:0] err_count;
  logic [15:0] err_addr;

  flex_dtack_watchdog #(
    .addr_bus_width(16),
    .data_bus_width(16),
    .timeout_cycles(32),
    .timeout_pattern(16'hDEAD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .addr(addr),
    .sec_addr_strobe(sec_addr_strobe),
    .rd_active(rd_active),
    .wr_active(wr_active),
    .slave_dtack(slave_dtack),
    .slave_data(slave_data),
    .clear_err(clear_err),
    .master_dtack(master_dtack),
    .master_data(master_data),
    .busy(busy),
    .timeout_flag(timeout_flag),
    .err_count(err_count),
    .err_addr(err_addr)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] data;
    logic        flag;
    logic [7:0]  cnt;
    logic [15:0] addr;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  logic [15:0] m_data = '0;
  logic        m_flag = 1'b0;
  logic [7:0]  m_cnt = '0;
  logic [15:0] m_addr = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (master_dtack === 1'b1) begin
      exp_t e;
      pulses++;
      if (sb.size() == 0) chk("spurious_dtack", 1, 0);
      else begin
        e = sb.pop_front();
        chk("master_data", master_data, e.data);
        chk("timeout_flag", timeout_flag, e.flag);
        chk("err_count", err_count, e.cnt);
        chk("err_addr", err_addr, e.addr);
      end
    end
  end

  task automatic run_cycle(input logic [15:0] a, input bit rd, input int k, input logic [15:0] d, input bit clr);
    bit ack;
    int ack_edge;
    int last;
    int p0;
    ack = (k >= 1 && k <= 32);
    ack_edge = ack ? k : 32;
    last = (k > 32) ? k : 32;
    if (ack) begin
      if (rd) m_data = d;
    end else begin
      if (rd) m_data = 16'hDEAD;
      m_flag = 1'b1;
      m_cnt = clr ? 8'd1 : (m_cnt == 8'hFF ? 8'hFF : m_cnt + 8'd1);
      m_addr = a;
    end
    sb.push_back('{m_data, m_flag, m_cnt, m_addr});
    p0 = pulses;
    addr = a;
    slave_data = d;
    sec_addr_strobe = 1'b1;
    rd_active = rd;
    wr_active = !rd;
    tick;
    addr = ~a;
    chk("busy_start", busy, 1);
    for (int i = 1; i <= last; i++) begin
      slave_dtack = (i == k);
      clear_err = (clr && i == 32);
      tick;
      slave_dtack = 1'b0;
      clear_err = 1'b0;
      if (i == ack_edge) chk("dtack_latency", master_dtack, 1);
    end
    sec_addr_strobe = 1'b0;
    rd_active = 1'b0;
    wr_active = 1'b0;
    tick;
    tick;
    chk("busy_end", busy, 0);
    chk("dtack_pulses", pulses - p0, 1);
  endtask

  initial begin
    int p0;
    repeat (3) tick;
    chk("rst_dtack", master_dtack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", master_data, 0);
    chk("rst_flag", timeout_flag, 0);
    chk("rst_count", err_count, 0);
    chk("rst_addr", err_addr, 0);
    reset = 1'b0;
    tick;

    run_cycle(16'h1000, 1, 3, 16'h1234, 0);
    chk("no_flag_after_ack", timeout_flag, 0);
    run_cycle(16'h0A40, 1, 0, 16'h5555, 0);
    run_cycle(16'h2000, 1, 32, 16'hBEEF, 0);
    run_cycle(16'h3000, 1, 33, 16'hCAFE, 0);
    run_cycle(16'h4000, 0, 5, 16'h7777, 0);
    run_cycle(16'h4100, 0, 0, 16'h8888, 0);
    run_cycle(16'h4200, 1, 1, 16'h0F0F, 0);

    p0 = pulses;
    addr = 16'h5000;
    sec_addr_strobe = 1'b1;
    rd_active = 1'b1;
    tick;
    repeat (5) tick;
    chk("abort_busy_before", busy, 1);
    sec_addr_strobe = 1'b0;
    rd_active = 1'b0;
    tick;
    chk("abort_busy", busy, 0);
    tick;
    chk("abort_pulses", pulses - p0, 0);
    chk("abort_flag", timeout_flag, m_flag);
    chk("abort_count", err_count, m_cnt);
    chk("abort_addr", err_addr, m_addr);

    for (int i = 0; i < 256; i++) run_cycle(16'h6000 + 16'(i), 1, 0, 16'h0, 0);
    chk("sat_count", err_count, 8'hFF);
    run_cycle(16'h7000, 1, 0, 16'h0, 1);
    chk("clr_coincident_count", err_count, 1);
    chk("clr_coincident_flag", timeout_flag, 1);

    clear_err = 1'b1;
    tick;
    clear_err = 1'b0;
    m_flag = 1'b0;
    m_cnt = 8'd0;
    chk("clr_flag", timeout_flag, 0);
    chk("clr_count", err_count, 0);
    chk("clr_keeps_addr", err_addr, 16'h7000);
    chk("clr_keeps_data", master_data, 16'hDEAD);

    addr = 16'h8000;
    sec_addr_strobe = 1'b1;
    rd_active = 1'b1;
    tick;
    repeat (3) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    sec_addr_strobe = 1'b0;
    rd_active = 1'b0;
    m_data = '0;
    m_addr = '0;
    chk("midrst_busy", busy, 0);
    chk("midrst_dtack", master_dtack, 0);
    chk("midrst_flag", timeout_flag, 0);
    chk("midrst_count", err_count, 0);
    chk("midrst_data", master_data, 0);
    tick;
    run_cycle(16'h9000, 1, 2, 16'hABCD, 0);
    run_cycle(16'h9100, 1, 0, 16'h0, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
